// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream packet generator.
// Holds the FSM state encoding used by axis_pkt_gen.
package axis_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream master that emits one incrementing-payload packet per start.
// Every master output comes straight from a flop; payload wraps naturally.
module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pkt_len,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] beat_q, beat_d;
    logic [DATA_W-1:0] beat_nxt;

    assign beat_nxt = beat_q + D_ONE;

    // Next-state: accept a packet in IDLE, advance a beat per handshake in SEND
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_d = SEND;
                    data_d  = seed;
                    valid_d = 1'b1;
                    last_d  = (pkt_len == D_ONE);
                    len_d   = pkt_len;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (valid_q && m_tready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + C_ONE;
                    end else begin
                        beat_d = beat_nxt;
                        data_d = data_q + D_ONE;
                        last_d = (beat_nxt == (len_q - D_ONE));
                    end
                end
            end
        endcase
    end

    // State register; reset abandons any packet without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    assign busy      = (state_q == SEND);
    assign done      = done_q;
    assign pkt_count = cnt_q;
    assign m_tdata   = data_q;
    assign m_tvalid  = valid_q;
    assign m_tlast   = last_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: stimulus queues expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pkt_len = 8'd0;
    logic [7:0]  seed = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    done_seen = 0;
    int    done_exp = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    axis_pkt_gen #(.DATA_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pkt_len  (pkt_len),
        .seed     (seed),
        .busy     (busy),
        .done     (done),
        .pkt_count(pkt_count),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [7:0] s, input int len);
        beat_t b;
        logic [7:0] v;
        v = s;
        for (int k = 0; k < len; k++) begin
            b.d = v;
            b.l = (k == len - 1);
            exp_q.push_back(b);
            v = v + 8'd1;
        end
        done_exp++;
    endtask

    task automatic wait_done(input string name, input int max_cyc,
                             input bit toggle, output int cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            tick();
            cyc++;
            if (toggle) m_tready = ~m_tready;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
        end
    endtask

    // Monitor: pops on accepted beats, checks stall stability and busy
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            chk("stall_valid", 32'(m_tvalid), 32'd1);
            chk("stall_data", 32'(m_tdata), 32'(prev_data));
            chk("stall_last", 32'(m_tlast), 32'(prev_last));
        end
        if (!reset) chk("busy_eq_valid", 32'(busy), 32'(m_tvalid));
        if (m_tvalid && m_tready && !reset) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL beat_unexpected: got data %0h last %0b",
                         m_tdata, m_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata !== e.d || m_tlast !== e.l) begin
                    n_errors++;
                    $display("FAIL beat: got data %0h last %0b expected %0h %0b",
                             m_tdata, m_tlast, e.d, e.l);
                end
            end
        end
        if (done) done_seen++;
        prev_stall = m_tvalid && !m_tready && !reset;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Test 1: reset state, then 4-beat packet at full rate
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(m_tvalid), 32'd0);
        chk("rst_last", 32'(m_tlast), 32'd0);
        chk("rst_data", 32'(m_tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(pkt_count), 32'd0);

        push_pkt(8'h10, 4);
        m_tready = 1'b1;
        start = 1'b1;
        pkt_len = 8'd4;
        seed = 8'h10;
        tick();
        start = 1'b0;
        chk("t1_valid_n1", 32'(m_tvalid), 32'd1);
        chk("t1_data0", 32'(m_tdata), 32'h10);
        wait_done("t1_done", 20, 1'b0, cyc);
        chk("t1_latency", 32'(cyc), 32'd4);
        chk("t1_count", 32'(pkt_count), 32'd1);
        chk("t1_valid_off", 32'(m_tvalid), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Test 2: payload wrap with toggling ready
        push_pkt(8'hFE, 3);
        start = 1'b1;
        pkt_len = 8'd3;
        seed = 8'hFE;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        pkt_len = 8'd9;
        seed = 8'h55;
        wait_done("t2_done", 30, 1'b1, cyc);
        chk("t2_count", 32'(pkt_count), 32'd2);
        m_tready = 1'b1;
        tick();

        // Test 3: single-beat packet
        push_pkt(8'hA5, 1);
        start = 1'b1;
        pkt_len = 8'd1;
        seed = 8'hA5;
        tick();
        start = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_last", 32'(m_tlast), 32'd1);
        chk("t3_data", 32'(m_tdata), 32'hA5);
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy_off", 32'(busy), 32'd0);
        chk("t3_count", 32'(pkt_count), 32'd3);
        tick();

        // Test 4: zero-length start and mid-packet start ignored
        start = 1'b1;
        pkt_len = 8'd0;
        seed = 8'h77;
        tick();
        start = 1'b0;
        chk("t4_len0_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_len0_done", 32'(done), 32'd0);
        chk("t4_len0_count", 32'(pkt_count), 32'd3);
        push_pkt(8'h20, 5);
        start = 1'b1;
        pkt_len = 8'd5;
        seed = 8'h20;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        pkt_len = 8'd2;
        seed = 8'h99;
        tick();
        start = 1'b0;
        wait_done("t4_done", 20, 1'b0, cyc);
        chk("t4_count", 32'(pkt_count), 32'd4);
        tick();
        tick();
        chk("t4_idle_after", 32'(busy), 32'd0);
        chk("t4_count_after", 32'(pkt_count), 32'd4);

        // Test 5: reset while stalled on beat 2 of a 6-beat packet
        exp_q.push_back('{d: 8'h40, l: 1'b0});
        exp_q.push_back('{d: 8'h41, l: 1'b0});
        start = 1'b1;
        pkt_len = 8'd6;
        seed = 8'h40;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        m_tready = 1'b0;
        chk("t5_beat2", 32'(m_tdata), 32'h42);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", 32'(m_tvalid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_count", 32'(pkt_count), 32'd0);
        chk("t5_data", 32'(m_tdata), 32'd0);
        tick();
        chk("t5_no_done", 32'(done), 32'd0);
        push_pkt(8'h01, 2);
        m_tready = 1'b1;
        start = 1'b1;
        pkt_len = 8'd2;
        seed = 8'h01;
        tick();
        start = 1'b0;
        wait_done("t5_done2", 20, 1'b0, cyc);
        chk("t5_count2", 32'(pkt_count), 32'd1);
        tick();

        // Test 6: start held high gives back-to-back 2-beat packets
        push_pkt(8'h30, 2);
        push_pkt(8'h30, 2);
        push_pkt(8'h30, 2);
        start = 1'b1;
        pkt_len = 8'd2;
        seed = 8'h30;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t6_valid", 32'(m_tvalid), 32'((i % 3) != 2));
            chk("t6_done", 32'(done), 32'((i % 3) == 2));
        end
        start = 1'b0;
        tick();
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_count", 32'(pkt_count), 32'd4);
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("done_total", 32'(done_seen), 32'(done_exp));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
